// File: rtl/sm_para_n_ch.sv
// sm_para_n_ch: CH independent IDLE/S1/S2/ERROR Moore FSMs with dwell timeout and saturating error counters
module sm_para_n_ch #(
    parameter int CH       = 4,
    parameter int TMO      = 8,
    parameter int CNT_W    = 4,
    parameter int AUTO_REC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         i1,
    input  logic [CH-1:0]         i2,
    input  logic                  err_clr,
    output logic [CH-1:0]         o1,
    output logic [CH-1:0]         o2,
    output logic [CH-1:0]         err,
    output logic                  err_any,
    output logic [CH*CNT_W-1:0]   err_cnt
);
    typedef enum logic [1:0] {IDLE, S1, S2, ERR} st_t;
    localparam logic [7:0] TMO_M1 = 8'(TMO - 1);
    localparam logic [7:0] TMO_8  = 8'(TMO);
    st_t        st [CH];
    st_t        nx [CH];
    logic [7:0] dw [CH];
    logic [CH-1:0] n_err;
    // next state per channel: transition table, then dwell timeout, then err_clr override
    always_comb begin
        n_err = '0;
        for (int n = 0; n < CH; n++) begin
            nx[n] = st[n] == IDLE ? (!i1[n] ? IDLE : i2[n] ? S1 : ERR) :
                    st[n] == S1   ? (!i2[n] ? S1 : i1[n] ? S2 : ERR) :
                    st[n] == S2   ? (i2[n] ? S2 : i1[n] ? IDLE : ERR) :
                    ((AUTO_REC != 0 && !i1[n] && !i2[n]) ? IDLE : ERR);
            if ((st[n] == S1 || st[n] == S2) && nx[n] == st[n] && dw[n] == TMO_M1)
                nx[n] = ERR;
            if (err_clr && nx[n] == ERR)
                nx[n] = IDLE;
            n_err[n] = nx[n] == ERR;
        end
    end
    // state, dwell and error counters plus outputs decoded from the next state into registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < CH; n++) begin
                st[n] <= IDLE;
                dw[n] <= '0;
            end
            o1      <= '0;
            o2      <= '0;
            err     <= '0;
            err_any <= 1'b0;
            err_cnt <= '0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                st[n] <= nx[n];
                dw[n] <= nx[n] != st[n] ? 8'd0 : dw[n] == TMO_8 ? dw[n] : dw[n] + 8'd1;
                err_cnt[n*CNT_W +: CNT_W] <= err_clr ? '0 :
                    (nx[n] == ERR && st[n] != ERR && err_cnt[n*CNT_W +: CNT_W] != '1) ?
                    err_cnt[n*CNT_W +: CNT_W] + CNT_W'(1) : err_cnt[n*CNT_W +: CNT_W];
                o1[n] <= nx[n] == S1 || nx[n] == S2;
                o2[n] <= nx[n] == S2;
            end
            err     <= n_err;
            err_any <= |n_err;
        end
    end
endmodule

// File: tb/tb_sm_para_n_ch.sv
// tb_sm_para_n_ch: scoreboard bench for the 4-channel FSM block with auto-recovery enabled
module tb_sm_para_n_ch;
    localparam int CH = 4, TMO = 8, CW = 4;
    typedef struct packed {
        logic [3:0]  o1;
        logic [3:0]  o2;
        logic [3:0]  err;
        logic        any;
        logic [15:0] cnt;
    } obs_t;
    logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
    logic [CH-1:0] i1 = '0, i2 = '0, o1, o2, err;
    logic err_any;
    logic [CH*CW-1:0] err_cnt;
    int n_cmp = 0, n_bad = 0;
    int ms [CH], md [CH], mc [CH];
    obs_t q [$];
    obs_t e, g;

    sm_para_n_ch #(.CH(CH), .TMO(TMO), .CNT_W(CW), .AUTO_REC(1)) dut (
        .clk(clk), .rst(rst), .i1(i1), .i2(i2), .err_clr(err_clr),
        .o1(o1), .o2(o2), .err(err), .err_any(err_any), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t get();
        return {o1, o2, err, err_any, err_cnt};
    endfunction

    // reference model: advance every channel by one edge and queue the expected outputs
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic clr, input logic r);
        obs_t x;
        int nx;
        x = '0;
        for (int n = 0; n < CH; n++) begin
            if (r) begin
                ms[n] = 0; md[n] = 0; mc[n] = 0;
            end else begin
                case (ms[n])
                    0: nx = !a[n] ? 0 : (b[n] ? 1 : 3);
                    1: nx = !b[n] ? 1 : (a[n] ? 2 : 3);
                    2: nx = b[n] ? 2 : (a[n] ? 0 : 3);
                    default: nx = (!a[n] && !b[n]) ? 0 : 3;
                endcase
                if ((ms[n] == 1 || ms[n] == 2) && nx == ms[n] && md[n] == TMO - 1) nx = 3;
                if (clr) begin
                    if (nx == 3) nx = 0;
                    mc[n] = 0;
                end else if (nx == 3 && ms[n] != 3 && mc[n] < 15) mc[n]++;
                if (nx != ms[n]) md[n] = 0;
                else if (md[n] < TMO) md[n]++;
                ms[n] = nx;
            end
            x.o1[n]  = ms[n] == 1 || ms[n] == 2;
            x.o2[n]  = ms[n] == 2;
            x.err[n] = ms[n] == 3;
            x.cnt[n*CW +: CW] = 4'(mc[n]);
        end
        x.any = |x.err;
        q.push_back(x);
    endtask

    task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic clr, input logic r);
        i1 = a; i2 = b; err_clr = clr; rst = r;
        model(a, b, clr, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(4'hF, 4'h3, 1'b1, 1'b1);
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL reset: got %h want %h", g, e); end
        end
        n_cmp++;
        if ({o1, o2, err, err_any, err_cnt} !== 29'd0) begin
            n_bad++; $display("FAIL reset_zero: got %h want 0", get());
        end
    endtask

    task automatic test_normal();
        logic [3:0] a [4] = '{4'h1, 4'h1, 4'h1, 4'h0};
        logic [3:0] b [4] = '{4'h1, 4'h1, 4'h0, 4'h0};
        logic [2:0] w1 = 3'b110, w2 = 3'b010;
        for (int k = 0; k < 4; k++) begin
            cyc(a[k], b[k], 1'b0, 1'b0);
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL normal[%0d]: got %h want %h", k, g, e); end
            if (k < 3) begin
                n_cmp++;
                if (o1[0] !== w1[2-k] || o2[0] !== w2[2-k] || err !== 4'h0) begin
                    n_bad++;
                    $display("FAIL normal_ch0[%0d]: got o1=%b o2=%b err=%b want o1=%b o2=%b err=0",
                             k, o1[0], o2[0], err, w1[2-k], w2[2-k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        cyc(4'h2, 4'h0, 1'b0, 1'b0);
        e = q.pop_front(); g = get(); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL illegal: got %h want %h", g, e); end
        n_cmp++;
        if (err !== 4'h2 || err_any !== 1'b1 || err_cnt !== 16'h0010 || o1 !== 4'h0) begin
            n_bad++; $display("FAIL illegal_ch1: got err=%b any=%b cnt=%h want 0010 1 0010", err, err_any, err_cnt);
        end
        cyc(4'h0, 4'h0, 1'b0, 1'b0);
        e = q.pop_front(); g = get(); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL autorec: got %h want %h", g, e); end
    endtask

    task automatic test_timeout();
        int c = 0;
        cyc(4'h4, 4'h4, 1'b0, 1'b0);
        e = q.pop_front(); g = get(); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL tmo_entry: got %h want %h", g, e); end
        while (err[2] !== 1'b1 && c < 20) begin
            cyc(4'h4, 4'h0, 1'b0, 1'b0);
            c++;
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL tmo[%0d]: got %h want %h", c, g, e); end
        end
        n_cmp++;
        if (c != TMO || err_cnt[11:8] !== 4'd1) begin
            n_bad++; $display("FAIL tmo_len: got %0d cycles cnt=%0d want 8 cycles cnt=1", c, err_cnt[11:8]);
        end
        cyc(4'h0, 4'h0, 1'b0, 1'b0);
        void'(q.pop_front());
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 16; k++) begin
            cyc(4'h8, 4'h0, 1'b0, 1'b0);
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e || err_cnt[15:12] === 4'd0) begin
                n_bad++; $display("FAIL sat[%0d]: got %h want %h", k, g, e);
            end
            cyc(4'h0, 4'h0, 1'b0, 1'b0);
            void'(q.pop_front());
        end
        n_cmp++;
        if (err_cnt[15:12] !== 4'd15) begin
            n_bad++; $display("FAIL sat_final: got %0d want 15", err_cnt[15:12]);
        end
    endtask

    task automatic test_priority();
        cyc(4'h1, 4'h0, 1'b1, 1'b0);
        e = q.pop_front(); g = get(); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL prio: got %h want %h", g, e); end
        n_cmp++;
        if (err[0] !== 1'b0 || o1[0] !== 1'b0 || err_cnt !== 16'h0) begin
            n_bad++; $display("FAIL prio_ch0: got err=%b cnt=%h want err0=0 cnt=0000", err, err_cnt);
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] a [4] = '{4'h3, 4'h3, 4'h3, 4'h1};
        logic [3:0] b [4] = '{4'h1, 4'h1, 4'h1, 4'h1};
        logic       r [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            cyc(a[k], b[k], 1'b0, r[k]);
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL rst_mid[%0d]: got %h want %h", k, g, e); end
            if (k == 1 && (o2[0] !== 1'b1 || err[1] !== 1'b1)) begin
                n_cmp++; n_bad++; $display("FAIL rst_setup: got o2=%b err=%b want o2[0]=1 err[1]=1", o2, err);
            end
            if (k == 2 && get() !== 29'd0) begin
                n_cmp++; n_bad++; $display("FAIL rst_zero: got %h want 0", get());
            end
            if (k == 3 && (o1 !== 4'h1 || o2 !== 4'h0)) begin
                n_cmp++; n_bad++; $display("FAIL rst_resume: got o1=%b o2=%b want 0001 0000", o1, o2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        logic c, r;
        for (int k = 0; k < 400; k++) begin
            a = 4'($urandom); b = 4'($urandom);
            c = $urandom_range(0, 19) == 0;
            r = $urandom_range(0, 79) == 0;
            if (k % 40 < 12) b = a | b;
            cyc(a, b, c, r);
            e = q.pop_front(); g = get(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", k, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_illegal();
        test_timeout();
        test_saturate();
        test_priority();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sm_para_n_ch.md
SM_PARA_N_CH -- requirements
Module: sm_para_n_ch

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent FSM channels (1..16).
REQ-002 SHALL have parameter TMO, default 8: max cycles a channel may dwell in S1 or S2 (2..255).
REQ-003 SHALL have parameter CNT_W, default 4: width of each per-channel error counter.
REQ-004 SHALL have parameter AUTO_REC, default 0: 1 = ERROR self-recovers to IDLE on i1=0,i2=0; 0 = recovery only via err_clr.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i1  input  CH  control input 1, bit n drives channel n.
REQ-008 SHALL have port i2  input  CH  control input 2, bit n drives channel n.
REQ-009 SHALL have port err_clr  input  1  synchronous clear of all channels' ERROR state and error counters.
REQ-010 SHALL have port o1  output  CH  bit n high while channel n is in S1 or S2.
REQ-011 SHALL have port o2  output  CH  bit n high while channel n is in S2.
REQ-012 SHALL have port err  output  CH  bit n high while channel n is in ERROR.
REQ-013 SHALL have port err_any  output  1  OR of all err bits.
REQ-014 SHALL have port err_cnt  output  CH*CNT_W  channel n count in bits [n*CNT_W +: CNT_W].

Function
REQ-015 SHALL give each channel an independent Moore FSM with states IDLE, S1, S2, ERROR; all outputs are decoded from registered state only (no combinational input-to-output path).
REQ-016 SHALL in IDLE: i1=0 -> IDLE; i1=1,i2=1 -> S1; i1=1,i2=0 -> ERROR.
REQ-017 SHALL in S1: i2=0 -> S1; i2=1,i1=1 -> S2; i2=1,i1=0 -> ERROR.
REQ-018 SHALL in S2: i2=1 -> S2; i2=0,i1=1 -> IDLE; i2=0,i1=0 -> ERROR.
REQ-019 SHALL in ERROR: stay in ERROR, except -> IDLE when AUTO_REC=1 and i1=0,i2=0.
REQ-020 SHALL keep a per-channel dwell counter, cleared on every state change, incremented each cycle the state holds, saturating at TMO.
REQ-021 SHALL force next state ERROR when the channel is in S1 or S2, its dwell counter equals TMO-1, and REQ-017/018 would hold the same state; a channel thus never spends more than TMO consecutive cycles in S1 or S2.
REQ-022 SHALL increment a channel's err_cnt by 1 on every entry into ERROR (from IDLE, S1, S2, or timeout), saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL on err_clr=1 move every channel in ERROR to IDLE and zero all err_cnt; channels in IDLE, S1 or S2 follow their normal transitions.
REQ-024 SHALL give err_clr priority over a same-cycle ERROR entry: that channel goes to IDLE and its err_cnt is 0.
REQ-025 SHALL reflect any state change on o1/o2/err/err_any in the cycle after the sampling edge (latency 1 clock).

Reset
REQ-026 SHALL on rst=1 at a rising edge put all channels in IDLE and zero all dwell counters and err_cnt, overriding err_clr and all inputs.
REQ-027 SHALL hold o1=0, o2=0, err=0, err_any=0, err_cnt=0 from the first edge with rst=1 until the first edge with rst=0, including rst asserted mid-sequence.

Verification
REQ-028 SHALL verify normal cycle, ch0: (i1,i2)=(1,1),(1,1),(1,0) on three edges -> ch0 states S1, S2, IDLE; o1=1,1,0; o2=0,1,0; err=0 throughout.
REQ-029 SHALL verify illegal entry, ch1: IDLE with (1,0) -> err[1]=1, err_any=1, err_cnt ch1=1; other channels unchanged.
REQ-030 SHALL verify timeout, TMO=8: ch2 enters S1 then holds (1,0) -> err[2] rises exactly 8 cycles after o1[2] rose; err_cnt ch2=1.
REQ-031 SHALL verify saturation, CNT_W=4: 16 ERROR entries on ch3 (with err_clr-free recovery via AUTO_REC=1) -> err_cnt ch3=15, never wraps to 0.
REQ-032 SHALL verify priority: err_clr=1 in the same cycle as an ERROR entry on ch0 -> ch0 IDLE, err[0]=0, all err_cnt=0.
REQ-033 SHALL verify reset mid-operation: rst=1 while ch0 in S2 and ch1 in ERROR -> next cycle all outputs 0; after rst=0, i1=1,i2=1 -> ch0 S1 one edge later.
